// File: rtl/police_dispatch_if.sv
// Color-mapper link for the police dispatcher: kill report in, car/officer/body drawing state out.
interface police_dispatch_if;
   localparam int unsigned W = 10;

   logic         personA_killed;
   logic [W-1:0] death_X;
   logic [W-1:0] death_Y;
   logic [W-1:0] police_car_X;
   logic [W-1:0] police_car_Y;
   logic [W-1:0] police_X;
   logic [W-1:0] police_Y;
   logic         police_out;
   logic         reached;
   logic         collected;
   logic         busy;

   modport master (
      input  personA_killed, death_X, death_Y,
      output police_car_X, police_car_Y, police_X, police_Y,
      output police_out, reached, collected, busy
   );

   modport slave (
      output personA_killed, death_X, death_Y,
      input  police_car_X, police_car_Y, police_X, police_Y,
      input  police_out, reached, collected, busy
   );
endinterface

// File: rtl/police_dispatch.sv
// Frame-paced police response: drive in, walk to body, collect, walk back, drive away.
// Optional dispatch delay (WAIT state) enabled by defining POLICE_DISPATCH_DELAY_EN.
module police_dispatch #(
   parameter int unsigned CAR_Y         = 400,
   parameter int unsigned CAR_HOME_X    = 720,
   parameter int unsigned CAR_SPEED     = 4,
   parameter int unsigned OFFICER_SPEED = 2,
   parameter int unsigned STOP_OFFSET   = 60,
   parameter int unsigned PICKUP_FRAMES = 30,
   parameter int unsigned DELAY_FRAMES  = 60
) (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   police_dispatch_if.master bus
);
   localparam int unsigned W          = 10;
   localparam int unsigned STOP_MAX_X = 604;
   localparam int unsigned BODY_DX    = 20;
   localparam int unsigned CNT_MAX    = (PICKUP_FRAMES > DELAY_FRAMES) ? PICKUP_FRAMES : DELAY_FRAMES;
   localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

   localparam logic [W-1:0] HOME_X   = W'(CAR_HOME_X);
   localparam logic [W-1:0] ROAD_Y   = W'(CAR_Y);
   localparam logic [W-1:0] CAR_STEP = W'(CAR_SPEED);
   localparam logic [W-1:0] OFF_STEP = W'(OFFICER_SPEED);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WAIT, ST_DRIVE_IN, ST_WALK_OUT, ST_PICKUP, ST_WALK_BACK, ST_DRIVE_OUT, ST_DONE
   } state_t;

   state_t           state;
   logic             frame_clk_q;
   logic             tick;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     stop_x;
   logic [W-1:0]     walk_x;
   logic [W-1:0]     walk_y;
   logic [W:0]       stop_sum;
   logic [W-1:0]     stop_new;
   logic [W-1:0]     car_in_nx, car_out_nx;
   logic [W-1:0]     out_x_nx, out_y_nx, back_x_nx, back_y_nx;

   // Snap to target when within one step; compare before subtracting so nothing wraps.
   function automatic logic [W-1:0] step_to(input logic [W-1:0] pos, input logic [W-1:0] tgt,
                                            input logic [W-1:0] spd);
      if (pos <= tgt) return ((tgt - pos) <= spd) ? tgt : pos + spd;
      return ((pos - tgt) <= spd) ? tgt : pos - spd;
   endfunction

   assign tick      = frame_clk & ~frame_clk_q;
   assign stop_sum  = (W+1)'(bus.death_X) + (W+1)'(STOP_OFFSET);
   assign stop_new  = (stop_sum > (W+1)'(STOP_MAX_X)) ? W'(STOP_MAX_X) : stop_sum[W-1:0];
   assign car_in_nx  = step_to(bus.police_car_X, stop_x, CAR_STEP);
   assign car_out_nx = step_to(bus.police_car_X, HOME_X, CAR_STEP);
   assign out_x_nx   = step_to(bus.police_X, walk_x, OFF_STEP);
   assign out_y_nx   = step_to(bus.police_Y, walk_y, OFF_STEP);
   assign back_x_nx  = step_to(bus.police_X, stop_x, OFF_STEP);
   assign back_y_nx  = step_to(bus.police_Y, ROAD_Y, OFF_STEP);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state            <= ST_IDLE;
         frame_clk_q      <= 1'b0;
         cnt              <= '0;
         stop_x           <= HOME_X;
         walk_x           <= HOME_X;
         walk_y           <= ROAD_Y;
         bus.police_car_X <= HOME_X;
         bus.police_car_Y <= ROAD_Y;
         bus.police_X     <= HOME_X;
         bus.police_Y     <= ROAD_Y;
         bus.police_out   <= 1'b0;
         bus.reached      <= 1'b0;
         bus.collected    <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         frame_clk_q <= frame_clk;
         case (state)
            ST_IDLE: if (bus.personA_killed) begin
               walk_x   <= bus.death_X + W'(BODY_DX);
               walk_y   <= bus.death_Y;
               stop_x   <= stop_new;
               cnt      <= '0;
               bus.busy <= 1'b1;
`ifdef POLICE_DISPATCH_DELAY_EN
               state    <= ST_WAIT;
`else
               state    <= ST_DRIVE_IN;
`endif
            end
`ifdef POLICE_DISPATCH_DELAY_EN
            ST_WAIT: if (tick) begin
               if (cnt == CNT_W'(DELAY_FRAMES - 1)) begin
                  cnt   <= '0;
                  state <= ST_DRIVE_IN;
               end else begin
                  cnt   <= cnt + CNT_W'(1);
               end
            end
`endif
            ST_DRIVE_IN: if (tick) begin
               bus.police_car_X <= car_in_nx;
               bus.police_X     <= car_in_nx;
               bus.police_Y     <= ROAD_Y;
               if (car_in_nx == stop_x) begin
                  bus.police_out <= 1'b1;
                  state          <= ST_WALK_OUT;
               end
            end
            ST_WALK_OUT: if (tick) begin
               bus.police_X <= out_x_nx;
               bus.police_Y <= out_y_nx;
               if (out_x_nx == walk_x && out_y_nx == walk_y) state <= ST_PICKUP;
            end
            ST_PICKUP: if (tick) begin
               if (cnt == CNT_W'(PICKUP_FRAMES - 1)) begin
                  cnt           <= '0;
                  bus.collected <= 1'b1;
                  state         <= ST_WALK_BACK;
               end else begin
                  cnt           <= cnt + CNT_W'(1);
               end
            end
            ST_WALK_BACK: if (tick) begin
               bus.police_X <= back_x_nx;
               bus.police_Y <= back_y_nx;
               if (back_x_nx == stop_x && back_y_nx == ROAD_Y) begin
                  bus.reached    <= 1'b1;
                  bus.police_out <= 1'b0;
                  state          <= ST_DRIVE_OUT;
               end
            end
            ST_DRIVE_OUT: if (tick) begin
               bus.police_car_X <= car_out_nx;
               bus.police_X     <= car_out_nx;
               bus.police_Y     <= ROAD_Y;
               if (car_out_nx == HOME_X) begin
                  bus.busy <= 1'b0;
                  state    <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_DONE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_police_dispatch.sv
// Directed bench for police_dispatch; delay-mode expectations follow POLICE_DISPATCH_DELAY_EN.
module tb_police_dispatch;
   logic Clk       = 1'b0;
   logic Reset     = 1'b1;
   logic frame_clk = 1'b0;
   int   checks    = 0;
   int   passed    = 0;

   police_dispatch_if bus();

   police_dispatch dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .frame_clk(frame_clk),
      .bus      (bus)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      else passed++;
   endtask

   // One frame: frame_clk high for one cycle, then low for two.
   task automatic ticks(input int n);
      repeat (n) begin
         @(negedge Clk) frame_clk = 1'b1;
         @(negedge Clk) frame_clk = 1'b0;
         @(negedge Clk);
      end
   endtask

   task automatic do_reset();
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
   endtask

   task automatic trigger(input int dx, input int dy);
      @(negedge Clk);
      bus.personA_killed = 1'b1;
      bus.death_X        = 10'(dx);
      bus.death_Y        = 10'(dy);
      @(negedge Clk);
      bus.personA_killed = 1'b0;
      chk("trig_busy", 32'(bus.busy), 1);
      chk("trig_car_x", 32'(bus.police_car_X), 720);
`ifdef POLICE_DISPATCH_DELAY_EN
      ticks(59);
      chk("delay_car_x_hold", 32'(bus.police_car_X), 720);
      ticks(1);
      chk("delay_car_x_end", 32'(bus.police_car_X), 720);
      chk("delay_busy", 32'(bus.busy), 1);
`endif
   endtask

   initial begin
      bus.personA_killed = 1'b0;
      bus.death_X        = '0;
      bus.death_Y        = '0;

      // Reset held across ticks
      Reset = 1'b1;
      ticks(3);
      chk("rst_car_x", 32'(bus.police_car_X), 720);
      chk("rst_car_y", 32'(bus.police_car_Y), 400);
      chk("rst_off_x", 32'(bus.police_X), 720);
      chk("rst_off_y", 32'(bus.police_Y), 400);
      chk("rst_flags", {29'd0, bus.police_out, bus.reached, bus.collected}, 0);
      chk("rst_busy", 32'(bus.busy), 0);
      @(negedge Clk) Reset = 1'b0;

      // Full sequence dX=300 dY=350
      trigger(300, 350);
      ticks(89);
      chk("in_car_x_89", 32'(bus.police_car_X), 364);
      chk("in_out_89", 32'(bus.police_out), 0);
      ticks(1);
      chk("in_car_x_90", 32'(bus.police_car_X), 360);
      chk("in_out_90", 32'(bus.police_out), 1);
      chk("in_off_x", 32'(bus.police_X), 360);
      chk("in_off_y", 32'(bus.police_Y), 400);
      ticks(24);
      chk("wo_off_x_24", 32'(bus.police_X), 320);
      chk("wo_off_y_24", 32'(bus.police_Y), 352);
      ticks(1);
      chk("wo_off_y_25", 32'(bus.police_Y), 350);
      chk("wo_coll", 32'(bus.collected), 0);
      ticks(29);
      chk("pk_coll_29", 32'(bus.collected), 0);
      ticks(1);
      chk("pk_coll_30", 32'(bus.collected), 1);
      ticks(24);
      chk("wb_off_x_24", 32'(bus.police_X), 360);
      chk("wb_off_y_24", 32'(bus.police_Y), 398);
      chk("wb_reached_24", 32'(bus.reached), 0);
      ticks(1);
      chk("wb_reached_25", 32'(bus.reached), 1);
      chk("wb_out_25", 32'(bus.police_out), 0);
      chk("wb_off_y_25", 32'(bus.police_Y), 400);
      ticks(89);
      chk("do_car_x_89", 32'(bus.police_car_X), 716);
      chk("do_busy_89", 32'(bus.busy), 1);
      ticks(1);
      chk("do_car_x_90", 32'(bus.police_car_X), 720);
      chk("do_off_x_90", 32'(bus.police_X), 720);
      chk("do_busy_90", 32'(bus.busy), 0);

      // DONE ignores a new kill
      @(negedge Clk) bus.personA_killed = 1'b1;
      ticks(3);
      bus.personA_killed = 1'b0;
      chk("done_busy", 32'(bus.busy), 0);
      chk("done_car_x", 32'(bus.police_car_X), 720);
      chk("done_flags", {30'd0, bus.reached, bus.collected}, 3);

      // Clamp: dX=600 -> stop at 604, officer target 620
      do_reset();
      trigger(600, 350);
      ticks(29);
      chk("cl_car_x", 32'(bus.police_car_X), 604);
      chk("cl_out", 32'(bus.police_out), 1);
      ticks(25);
      chk("cl_off_x", 32'(bus.police_X), 620);
      chk("cl_off_y", 32'(bus.police_Y), 350);
      ticks(30);
      chk("cl_coll", 32'(bus.collected), 1);

      // Non-multiple: dX=301 -> stop 361, final 3-px step
      do_reset();
      trigger(301, 350);
      ticks(89);
      chk("nm_car_x_89", 32'(bus.police_car_X), 364);
      ticks(1);
      chk("nm_car_x_90", 32'(bus.police_car_X), 361);
      chk("nm_out", 32'(bus.police_out), 1);
      ticks(3);
      chk("nm_car_x_hold", 32'(bus.police_car_X), 361);
      chk("nm_off_x", 32'(bus.police_X), 355);

      // Reset in WALK_OUT, then a fresh kill
      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk);
      chk("mr_car_x", 32'(bus.police_car_X), 720);
      chk("mr_off_x", 32'(bus.police_X), 720);
      chk("mr_off_y", 32'(bus.police_Y), 400);
      chk("mr_out", 32'(bus.police_out), 0);
      chk("mr_busy", 32'(bus.busy), 0);
      Reset = 1'b0;
      trigger(300, 350);
      ticks(1);
      chk("mr_restart_car_x", 32'(bus.police_car_X), 716);
      chk("mr_restart_off_x", 32'(bus.police_X), 716);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
